// File: rtl/cmp_seq.sv
// Multi-cycle signed/unsigned magnitude/equality comparator that scans MSB-first, one slice per
// cycle, with early exit. Operands and result each use a valid/ready handshake.
module cmp_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       flag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [3:0]        flag_q;
  logic [IdxW-1:0]   idx_q;
  logic              eq_q, lt_q;

  logic [SLICE-1:0]  slice_a, slice_b;
  int unsigned       shamt;
  logic              cond_res;

  always_comb begin
    shamt   = 32'(idx_q) * SLICE;
    slice_a = SLICE'(a_q >> shamt);
    slice_b = SLICE'(b_q >> shamt);
    // Flipping the sign bits of the top slice turns an unsigned compare into a signed one.
    if (idx_q == IdxTop && !flag_q[3]) begin
      slice_a[SLICE-1] = ~slice_a[SLICE-1];
      slice_b[SLICE-1] = ~slice_b[SLICE-1];
    end
  end

  always_comb begin
    case (flag_q[2:0])
      3'b001:  cond_res = eq_q;
      3'b000:  cond_res = ~eq_q;
      3'b010:  cond_res = lt_q;
      3'b110:  cond_res = lt_q | eq_q;
      3'b100:  cond_res = ~lt_q;
      3'b111:  cond_res = ~lt_q & ~eq_q;
      default: cond_res = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      flag_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            flag_q  <= flag;
            idx_q   <= IdxTop;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (slice_a != slice_b) begin
            lt_q    <= slice_a < slice_b;
            eq_q    <= 1'b0;
            state_q <= StDone;
          end else if (idx_q != '0) begin
            idx_q   <= idx_q - IdxW'(1);
          end else begin
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign s         = out_valid & cond_res;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Directed and random bench for cmp_seq; expected results come from whole-word arithmetic.
module tb_cmp_seq;
  localparam int W  = 32;
  localparam int SL = 8;
  localparam int N  = W / SL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0;
  logic [3:0]    flag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          s, eq, lt, busy;

  int errors = 0;
  int checks = 0;

  cmp_seq #(.WIDTH(W), .SLICE(SL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .flag(flag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .s(s), .eq(eq),
    .lt(lt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_lt(input logic [W-1:0] x, input logic [W-1:0] y, input bit u);
    if (u) return x < y;
    return $signed(x) < $signed(y);
  endfunction

  function automatic bit m_s(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] f);
    bit e, l;
    e = (x == y);
    l = m_lt(x, y, f[3]);
    case (f[2:0])
      3'b001:  return e;
      3'b000:  return !e;
      3'b010:  return l;
      3'b110:  return l || e;
      3'b100:  return !l;
      3'b111:  return !l && !e;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int m_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int j = 0; j < N; j++) begin
      int sh;
      sh = (N - 1 - j) * SL;
      if (((x >> sh) & 32'hFF) != ((y >> sh) & 32'hFF)) return j + 1;
    end
    return N;
  endfunction

  // Present a request, wait for its accept edge, then scramble the inputs.
  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] f);
    @(negedge clk);
    a = x; b = y; flag = f; in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; flag = 4'($urandom);
  endtask

  task automatic wait_result(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] f,
                             input string tag);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    for (int i = 1; i <= N + 3 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        cyc = i;
      end
    end
    if (!seen) begin
      errors++;
      $error("FAIL %s: timed out waiting for out_valid", tag);
    end
    chk({tag, "_latency"}, cyc, m_lat(x, y));
    if (seen) begin
      chk({tag, "_s"}, s, m_s(x, y, f));
      chk({tag, "_eq"}, eq, (x == y));
      chk({tag, "_lt"}, lt, m_lt(x, y, f[3]));
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_dropped"}, out_valid, 1'b0);
    chk({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] f,
                     input string tag);
    start(x, y, f);
    wait_result(x, y, f, tag);
    release_result(tag);
  endtask

  initial begin
    logic [W-1:0] x, y, x2, y2;
    logic [3:0]   f, f2;
    bit           s0, eq0, lt0, ov_seen;

    #2;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_s", s, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_eq", eq, 1'b0);
    chk("reset_lt", lt, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run(32'h12345678, 32'h12345678, 4'b0001, "eq_full");
    run(32'hFFFFFFFF, 32'h00000001, 4'b0010, "signed_lt");
    run(32'hFFFFFFFF, 32'h00000001, 4'b1010, "unsigned_lt");
    run(32'h00000005, 32'h00000000, 4'b0111, "gt");
    run(32'h00000005, 32'h00000000, 4'b0110, "le");
    run(32'h80000000, 32'h00000000, 4'b0100, "gez");
    run($urandom, $urandom, 4'b0011, "rsvd_011");
    run($urandom, $urandom, 4'b1101, "rsvd_101");

    // Backpressure: result held while a new request waits.
    x = 32'h0000_1200; y = 32'h0000_1300; f = 4'b1110;
    x2 = 32'h7000_0000; y2 = 32'h8000_0000; f2 = 4'b0111;
    start(x, y, f);
    wait_result(x, y, f, "bp_first");
    s0 = s; eq0 = eq; lt0 = lt;
    @(negedge clk);
    a = x2; b = y2; flag = f2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_stall_out_valid", out_valid, 1'b1);
      chk("bp_stall_s", s, s0);
      chk("bp_stall_eq", eq, eq0);
      chk("bp_stall_lt", lt, lt0);
      chk("bp_stall_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", in_ready, 1'b1);
    chk("bp_idle_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", busy, 1'b1);
    wait_result(x2, y2, f2, "bp_second");
    release_result("bp_second");

    // Flush during scan cycle 2.
    start(32'hAAAAAAAA, 32'hAAAAAAAA, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_busy", busy, 1'b0);
    ov_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
    end
    chk("flush_no_out_valid", ov_seen, 1'b0);

    // Asynchronous reset mid-scan.
    start(32'hAAAAAAAA, 32'hAAAAAAAA, 4'b0001);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", out_valid, 1'b0);
    chk("areset_in_ready", in_ready, 1'b1);
    chk("areset_busy", busy, 1'b0);
    chk("areset_s", s, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'hAAAAAAAA, 32'hAAAAAAAA, 4'b0001, "after_reset");

    for (int k = 0; k < 40; k++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = $urandom;
        1:       y = x;
        2:       y = x ^ (32'h1 << $urandom_range(0, W - 1));
        default: y = '0;
      endcase
      f = 4'($urandom);
      run(x, y, f, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
